// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================
// ps2_pkg : shared types and constants for the PS/2 host receiver
// rev 1.0
// ============================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/ps2_scancode_decode.sv
`default_nettype none
// ============================================================
// ps2_scancode_decode : folds E0/F0 prefixes into key events
// rev 1.0
// ============================================================
module ps2_scancode_decode
  import ps2_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] key_code,
  output logic       key_strobe,
  output logic       key_extended,
  output logic       key_released
);

  logic ext;
  logic rel;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext          <= 1'b0;
      rel          <= 1'b0;
      key_code     <= 8'h00;
      key_strobe   <= 1'b0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (rx_err) begin
        // A corrupted frame may have been a key byte; never carry prefixes past it
        ext <= 1'b0;
        rel <= 1'b0;
      end else if (rx_valid) begin
        if (rx_data == PS2_PFX_EXT) begin
          ext <= 1'b1;
        end else if (rx_data == PS2_PFX_REL) begin
          rel <= 1'b1;
        end else begin
          key_code     <= rx_data;
          key_extended <= ext;
          key_released <= rel;
          key_strobe   <= 1'b1;
          ext          <= 1'b0;
          rel          <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_host_rx.sv
`default_nettype none
// ============================================================
// ps2_host_rx : PS/2 host receiver with glitch filter, frame checks,
//               timeout and scancode prefix decoding.  rev 1.0
// ============================================================
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 2047
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] rx_err_code,
  output logic       busy,
  output logic [7:0] key_code,
  output logic       key_strobe,
  output logic       key_extended,
  output logic       key_released
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_f;
  logic          clk_f_d;
  logic [3:0]    filt_cnt;
  logic          fall;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity;
  logic [TW-1:0] to_cnt;

  assign fall = clk_f_d & ~clk_f;
  assign busy = (state != IDLE);

  // clk_f only moves once the synced clock has disagreed with it for FILTER_LEN cycles
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_f     <= 1'b1;
      clk_f_d   <= 1'b1;
      filt_cnt  <= 4'd0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_f_d   <= clk_f;
      if (clk_sync[1] == clk_f) begin
        filt_cnt <= 4'd0;
      end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
        clk_f    <= clk_sync[1];
        filt_cnt <= 4'd0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      parity      <= 1'b0;
      to_cnt      <= '0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= 2'b00;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      // An edge arriving together with the timeout is still a valid bit
      if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data_sync[1]) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              rx_err      <= 1'b1;
              rx_err_code <= ERR_FRAME;
            end
          end
          DATA: begin
            shreg   <= {data_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity <= data_sync[1];
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_sync[1]) begin
              rx_err      <= 1'b1;
              rx_err_code <= ERR_FRAME;
            end else if (^{shreg, parity}) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_err      <= 1'b1;
              rx_err_code <= ERR_PARITY;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          state       <= IDLE;
          to_cnt      <= '0;
          rx_err      <= 1'b1;
          rx_err_code <= ERR_TIMEOUT;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

  ps2_scancode_decode u_decode (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_err       (rx_err),
    .key_code     (key_code),
    .key_strobe   (key_strobe),
    .key_extended (key_extended),
    .key_released (key_released)
  );

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_rx.sv
`default_nettype none
// ============================================================
// tb_ps2_host_rx : scoreboard bench for the PS/2 host receiver
// rev 1.0
// ============================================================
module tb_ps2_host_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 2047;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [1:0] rx_err_code;
  logic       busy;
  logic [7:0] key_code;
  logic       key_strobe;
  logic       key_extended;
  logic       key_released;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic [1:0] code;
  } rx_exp_t;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_exp_t;

  rx_exp_t  rx_q[$];
  key_exp_t key_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   t_fall = 0;
  logic prev_valid = 1'b0;

  ps2_host_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_err       (rx_err),
    .rx_err_code  (rx_err_code),
    .busy         (busy),
    .key_code     (key_code),
    .key_strobe   (key_strobe),
    .key_extended (key_extended),
    .key_released (key_released)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic exp_rx(input logic is_err, input logic [7:0] data, input logic [1:0] code);
    rx_exp_t e;
    e.is_err = is_err; e.data = data; e.code = code;
    rx_q.push_back(e);
  endtask

  task automatic exp_key(input logic [7:0] code, input logic ext, input logic rel);
    key_exp_t k;
    k.code = code; k.ext = ext; k.rel = rel;
    key_q.push_back(k);
  endtask

  // bits[0] is the start bit; device changes data while the clock is high
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(50);
      ps2_clk = 1'b0;
      t_fall  = cyc;
      wait_cyc(100);
      ps2_clk = 1'b1;
      if (glitch) begin
        wait_cyc(20);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(28);
      end else begin
        wait_cyc(50);
      end
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic stop, input bit glitch);
    send_bits(frame(b, bad_par, stop), 11, glitch);
    wait_cyc(20);
  endtask

  task automatic good_byte(input logic [7:0] b);
    exp_rx(1'b0, b, 2'b00);
    send_byte(b, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (rx_valid || rx_err) begin
        if (rx_q.size() == 0) begin
          check("rx_unexpected", {rx_valid, rx_err}, 32'd0);
        end else begin
          rx_exp_t e;
          e = rx_q.pop_front();
          check("rx_kind", rx_err, e.is_err);
          if (e.is_err) begin
            check("rx_err_code", rx_err_code, e.code);
            if (e.code == 2'b11)
              check("timeout_latency", cyc - t_fall, 3 + FILTER_LEN + TIMEOUT);
          end else begin
            check("rx_data", rx_data, e.data);
          end
        end
      end
      if (key_strobe) begin
        check("strobe_latency", prev_valid, 1'b1);
        if (key_q.size() == 0) begin
          check("key_unexpected", key_strobe, 1'b0);
        end else begin
          key_exp_t k;
          k = key_q.pop_front();
          check("key_code", key_code, k.code);
          check("key_extended", key_extended, k.ext);
          check("key_released", key_released, k.rel);
        end
      end
    end
    prev_valid <= rx_valid;
  end

  initial begin
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_flags", {rx_valid, rx_err, busy, key_strobe}, 4'b0000);
    check("rst_err_code", rx_err_code, 2'b00);
    check("rst_key", {key_code, key_extended, key_released}, 10'd0);
    wait_cyc(10);

    // plain make code
    exp_key(8'h1C, 1'b0, 1'b0);
    good_byte(8'h1C);

    // extended release, then a plain make
    good_byte(8'hE0);
    good_byte(8'hF0);
    exp_key(8'h75, 1'b1, 1'b1);
    good_byte(8'h75);
    exp_key(8'h75, 1'b0, 1'b0);
    good_byte(8'h75);

    // parity error drops the pending E0
    good_byte(8'hE0);
    exp_rx(1'b1, 8'h00, 2'b01);
    send_byte(8'h1C, 1'b1, 1'b1, 1'b0);
    good_byte(8'hF0);
    exp_key(8'h1C, 1'b0, 1'b1);
    good_byte(8'h1C);

    // stop bit 0 beats bad parity; lone fall with data high is a framing error
    exp_rx(1'b1, 8'h00, 2'b10);
    send_byte(8'h1C, 1'b1, 1'b0, 1'b0);
    exp_rx(1'b1, 8'h00, 2'b10);
    send_bits(11'h7FF, 1, 1'b0);
    wait_cyc(20);

    // truncated frame: start + 3 bits then clock idles high
    exp_rx(1'b1, 8'h00, 2'b11);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 4, 1'b0);
    wait_cyc(TIMEOUT + 200);
    check("busy_after_timeout", busy, 1'b0);
    exp_key(8'h5A, 1'b0, 1'b0);
    good_byte(8'h5A);

    // short clock glitches during high phases
    exp_rx(1'b0, 8'h5A, 2'b00);
    exp_key(8'h5A, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b1, 1'b1);

    // reset in the middle of a frame
    send_bits(frame(8'h1C, 1'b0, 1'b1), 5, 1'b0);
    check("busy_mid_frame", busy, 1'b1);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    check("busy_after_reset", busy, 1'b0);
    check("flags_after_reset", {rx_valid, rx_err}, 2'b00);
    wait_cyc(20);
    exp_key(8'h29, 1'b0, 1'b0);
    good_byte(8'h29);

    // E1 is not a prefix here
    exp_key(8'hE1, 1'b0, 1'b0);
    good_byte(8'hE1);

    wait_cyc(100);
    check("rx_queue_drained", rx_q.size(), 0);
    check("key_queue_drained", key_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
